// File: rtl/mips_cpu.sv
// mips_cpu: single-cycle 32-bit MIPS subset core (add/sub/and/or/slt, addi, lw, sw, beq, bne, j).
// Latency: one instruction per clock; register-file, data-memory and PC updates all land on the same rising edge.
// Backpressure: none. The core free-runs whenever reset is low. Unknown opcodes and functs retire as NOPs.
// Ports: clock (rising edge), reset (synchronous, active high; resets only the PC).
// Benches preload Registers_0.data, InstructionMemory_0.data and DataMemory_0.data hierarchically.

// Register file: two combinational read ports and one write port. $0 reads as zero and ignores writes.
// Ports: clock, i_we/i_wa/i_wd write port, i_ra1/i_ra2 read addresses, o_rd1/o_rd2 read data.
module mips_regs (
    input  logic        clock,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    // No reset: the contents must survive reset.
    reg [31:0] data [0:31];

    always @(posedge clock) begin
        if (i_we && (i_wa != 5'd0))
            data[i_wa] <= i_wd;
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : data[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : data[i_ra2];
endmodule

// Word-addressed memory with a combinational read and a clocked write. Used for both instructions and data.
// Ports: clock, i_we/i_wa/i_wd write port, i_ra read word index, o_rd read data.
module mips_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [31:0]   i_wd,
    input  logic [AW-1:0] i_ra,
    output logic [31:0]   o_rd
);
    reg [31:0] data [0:DEPTH-1];

    always @(posedge clock) begin
        if (i_we)
            data[i_wa] <= i_wd;
    end

    assign o_rd = data[i_ra];
endmodule

module mips_cpu #(
    parameter int INSTR_MEM_SIZE = 32,
    parameter int DATA_MEM_SIZE  = 64
) (
    input  logic clock,
    input  logic reset
);
    localparam int IW = $clog2(INSTR_MEM_SIZE);
    localparam int DW = $clog2(DATA_MEM_SIZE);

    logic [31:0] r_pc;

    logic [31:0] w_instr;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_dmem_rd;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_simm;
    logic [31:0] w_addr;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;

    // Decoded control, driven by the decode block below.
    logic        w_reg_we;
    logic [4:0]  w_wa;
    logic [31:0] w_wd;
    logic        w_mem_we;
    logic [31:0] w_pc_next;

    assign w_op       = w_instr[31:26];
    assign w_rs       = w_instr[25:21];
    assign w_rt       = w_instr[20:16];
    assign w_rd       = w_instr[15:11];
    assign w_funct    = w_instr[5:0];
    assign w_simm     = {{16{w_instr[15]}}, w_instr[15:0]};
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_addr     = w_rs_val + w_simm;

    // Shamt and the upper PC/address bits are architecturally ignored. The memories wrap.
    logic w_unused;
    assign w_unused = &{1'b0, w_instr[10:6], w_addr[31:DW+2], w_addr[1:0]};

    // The instruction memory is loaded by the bench. Its write port is tied off.
    mips_mem #(.DEPTH(INSTR_MEM_SIZE)) InstructionMemory_0 (
        .clock (clock),
        .i_we  (1'b0),
        .i_wa  ({IW{1'b0}}),
        .i_wd  (32'd0),
        .i_ra  (r_pc[IW+1:2]),
        .o_rd  (w_instr)
    );

    // Writes are gated by reset, which aborts the in-flight instruction.
    mips_regs Registers_0 (
        .clock (clock),
        .i_we  (w_reg_we & ~reset),
        .i_wa  (w_wa),
        .i_wd  (w_wd),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_rs_val),
        .o_rd2 (w_rt_val)
    );

    mips_mem #(.DEPTH(DATA_MEM_SIZE)) DataMemory_0 (
        .clock (clock),
        .i_we  (w_mem_we & ~reset),
        .i_wa  (w_addr[DW+1:2]),
        .i_wd  (w_rt_val),
        .i_ra  (w_addr[DW+1:2]),
        .o_rd  (w_dmem_rd)
    );

    always_comb begin
        w_reg_we  = 1'b0;
        w_wa      = w_rt;
        w_wd      = w_addr;
        w_mem_we  = 1'b0;
        w_pc_next = w_pc_plus4;
        case (w_op)
            6'h00: begin
                w_wa     = w_rd;
                w_reg_we = 1'b1;
                case (w_funct)
                    6'h20:   w_wd = w_rs_val + w_rt_val;
                    6'h22:   w_wd = w_rs_val - w_rt_val;
                    6'h24:   w_wd = w_rs_val & w_rt_val;
                    6'h25:   w_wd = w_rs_val | w_rt_val;
                    6'h2A:   w_wd = {31'd0, $signed(w_rs_val) < $signed(w_rt_val)};
                    default: w_reg_we = 1'b0;
                endcase
            end
            6'h08: w_reg_we = 1'b1;
            6'h23: begin
                w_reg_we = 1'b1;
                w_wd     = w_dmem_rd;
            end
            6'h2B: w_mem_we = 1'b1;
            6'h04: if (w_rs_val == w_rt_val) w_pc_next = w_pc_plus4 + {w_simm[29:0], 2'b00};
            6'h05: if (w_rs_val != w_rt_val) w_pc_next = w_pc_plus4 + {w_simm[29:0], 2'b00};
            6'h02: w_pc_next = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_pc <= 32'd0;
        else
            r_pc <= w_pc_next;
    end
endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu: directed program against an instruction-level reference model of the core.
// Latency: the model retires one instruction per rising edge. Outputs are compared on the falling edge.
// Backpressure: not applicable; the bench drives only clock and reset.
module tb_mips_cpu;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mips_cpu dut (.clock(clock), .reset(reset));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_reg  [0:31];
    logic [31:0] m_dmem [0:63];
    logic [31:0] m_imem [0:31];
    logic [31:0] m_pc;

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] f);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    // Instruction-set model: executes the instruction at m_pc using plain ISA arithmetic.
    always @(posedge clock) begin : model
        logic [31:0] ins, a, b, imm, nxt, ea;
        int rd, rt;
        if (reset) begin
            m_pc = 32'd0;
        end else begin
            ins = m_imem[(m_pc / 4) % 32];
            a   = m_reg[ins[25:21]];
            b   = m_reg[ins[20:16]];
            rt  = int'(ins[20:16]);
            rd  = int'(ins[15:11]);
            imm = 32'($signed(ins[15:0]));
            ea  = a + imm;
            nxt = m_pc + 4;
            case (ins[31:26])
                6'h00: begin
                    case (ins[5:0])
                        6'h20: if (rd != 0) m_reg[rd] = a + b;
                        6'h22: if (rd != 0) m_reg[rd] = a - b;
                        6'h24: if (rd != 0) m_reg[rd] = a & b;
                        6'h25: if (rd != 0) m_reg[rd] = a | b;
                        6'h2A: if (rd != 0) m_reg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: ;
                    endcase
                end
                6'h08: if (rt != 0) m_reg[rt] = ea;
                6'h23: if (rt != 0) m_reg[rt] = m_dmem[(ea / 4) % 64];
                6'h2B: m_dmem[(ea / 4) % 64] = b;
                6'h04: if (a == b) nxt = nxt + imm * 4;
                6'h05: if (a != b) nxt = nxt + imm * 4;
                6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
                default: ;
            endcase
            m_pc = nxt;
        end
    end

    // Full architectural state compare on every falling edge once the core is out of power-up.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("pc", dut.r_pc, m_pc);
            for (int i = 0; i < 32; i++)
                chk($sformatf("reg%0d", i), dut.Registers_0.data[i], m_reg[i]);
            for (int i = 0; i < 64; i++)
                chk($sformatf("dmem%0d", i), dut.DataMemory_0.data[i], m_dmem[i]);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 32; i++) m_imem[i] = 32'h0000_0000;
        m_imem[0]  = enc_i(6'h04, 1, 1, 16'd2);          // beq $1,$1,+2 -> 12
        m_imem[1]  = enc_i(6'h08, 0, 20, 16'd99);        // skipped
        m_imem[2]  = enc_i(6'h08, 0, 21, 16'd99);        // skipped
        m_imem[3]  = enc_r(4, 5, 10, 6'h20);             // add $10,$4,$5
        m_imem[4]  = enc_r(4, 5, 11, 6'h22);             // sub $11,$4,$5
        m_imem[5]  = enc_i(6'h2B, 0, 5, 16'd8);          // sw $5,8($0)
        m_imem[6]  = enc_i(6'h23, 0, 12, 16'd8);         // lw $12,8($0)
        m_imem[7]  = enc_i(6'h08, 12, 13, 16'hFFF9);     // addi $13,$12,-7
        m_imem[8]  = enc_i(6'h05, 1, 1, 16'd2);          // bne $1,$1,+2 (not taken)
        m_imem[9]  = enc_r(1, 2, 14, 6'h2A);             // slt $14,$1,$2
        m_imem[10] = enc_r(2, 1, 15, 6'h2A);             // slt $15,$2,$1
        m_imem[11] = enc_r(1, 2, 0, 6'h20);              // add $0,$1,$2
        m_imem[12] = enc_r(6, 3, 16, 6'h24);             // and $16,$6,$3
        m_imem[13] = enc_r(6, 3, 17, 6'h25);             // or  $17,$6,$3
        m_imem[14] = {6'h3F, 26'h3FF_FFFF};              // unknown opcode
        m_imem[15] = enc_i(6'h08, 18, 18, 16'd1);        // addi $18,$18,1
        m_imem[16] = enc_j(26'd31);                      // j 124
        m_imem[31] = enc_j(26'd32);                      // j 128 -> wraps to index 0
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'(i);
            dut.Registers_0.data[i] <= 32'(i);
            dut.InstructionMemory_0.data[i] <= m_imem[i];
        end
        for (int i = 0; i < 64; i++) begin
            m_dmem[i] = 32'hA000_0000 + 32'(i);
            dut.DataMemory_0.data[i] <= 32'hA000_0000 + 32'(i);
        end
        m_pc = 32'd0;

        step();
        step();
        chk_en = 1'b1;
        chk("reset_pc", dut.r_pc, 32'd0);
        chk("reset_r5", dut.Registers_0.data[5], 32'd5);
        chk("reset_dmem2", dut.DataMemory_0.data[2], 32'hA000_0002);
        reset = 1'b0;

        step(); chk("beq_taken_pc", dut.r_pc, 32'd12);
                chk("beq_skip_r20", dut.Registers_0.data[20], 32'd20);
        step(); chk("add_r10", dut.Registers_0.data[10], 32'd9);
        step(); chk("sub_r11", dut.Registers_0.data[11], 32'hFFFF_FFFF);
        step(); chk("sw_dmem2", dut.DataMemory_0.data[2], 32'd5);
        step(); chk("lw_r12", dut.Registers_0.data[12], 32'd5);
        step(); chk("addi_r13", dut.Registers_0.data[13], 32'hFFFF_FFFE);
        step(); chk("bne_not_taken_pc", dut.r_pc, 32'd36);
        step(); chk("slt_r14", dut.Registers_0.data[14], 32'd1);
        step(); chk("slt_r15", dut.Registers_0.data[15], 32'd0);
        step(); chk("r0_zero", dut.Registers_0.data[0], 32'd0);
        step(); chk("and_r16", dut.Registers_0.data[16], 32'd2);
        step(); chk("or_r17", dut.Registers_0.data[17], 32'd7);
        step(); chk("nop_pc", dut.r_pc, 32'd60);
                chk("nop_r18", dut.Registers_0.data[18], 32'd18);
        step(); chk("addi_r18", dut.Registers_0.data[18], 32'd19);
        step(); chk("j_pc", dut.r_pc, 32'd124);
        step(); chk("j_wrap_pc", dut.r_pc, 32'd128);
        step(); chk("wrap_fetch_beq_pc", dut.r_pc, 32'd140);
        repeat (4) step();

        reset = 1'b1;
        step(); chk("midreset_pc", dut.r_pc, 32'd0);
                chk("midreset_r10", dut.Registers_0.data[10], 32'd9);
                chk("midreset_r12", dut.Registers_0.data[12], 32'd5);
        reset = 1'b0;
        step(); chk("restart_pc", dut.r_pc, 32'd12);
        step();
        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
